// File: rtl/core_div_pkg.sv
// ============================================================================
// Module      : core_div_pkg
// Description : Shared types and constants for the iterative RV32M divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam int DIV_ITER = 32;
    localparam int CNT_W    = 5;

endpackage

`default_nettype wire

// File: rtl/core_div_iter.sv
// ============================================================================
// Module      : core_div_iter
// Description : Radix-2 restoring divider for DIV/DIVU/REM/REMU, 34-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_div_iter
    import core_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            ack_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e             state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic                   is_rem_q, is_rem_d;
    logic                   qneg_q,   qneg_d;
    logic                   rneg_q,   rneg_d;
    logic [XLEN-1:0]        quo_q,    quo_d;
    logic [XLEN-1:0]        rem_q,    rem_d;
    logic [XLEN-1:0]        dvs_q,    dvs_d;
    logic [XLEN-1:0]        result_q, result_d;

    logic                   w_signed;
    logic                   w_is_rem;
    logic [XLEN-1:0]        w_dvd_abs;
    logic [XLEN-1:0]        w_dvs_abs;
    logic [XLEN:0]          w_shift;
    logic [XLEN:0]          w_diff;
    logic [XLEN-1:0]        w_quo_fix;
    logic [XLEN-1:0]        w_rem_fix;

    assign w_signed  = (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    assign w_is_rem  = (funct3_i == F3_REM) || (funct3_i == F3_REMU);
    assign w_dvd_abs = (w_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    assign w_dvs_abs = (w_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

    // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    assign w_shift   = {rem_q, quo_q[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, dvs_q};
    assign w_quo_fix = qneg_q ? -quo_q : quo_q;
    assign w_rem_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_rem_d = is_rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i && funct3_i[2]) begin
                    is_rem_d = w_is_rem;
                    qneg_d   = w_signed && (dividend_i[XLEN-1] != divisor_i[XLEN-1]);
                    rneg_d   = w_signed && dividend_i[XLEN-1];
                    quo_d    = w_dvd_abs;
                    dvs_d    = w_dvs_abs;
                    rem_d    = '0;
                    if (divisor_i == '0) begin
                        result_d = w_is_rem ? dividend_i : '1;
                        state_d  = DONE;
                    end else if (w_signed && (dividend_i == C_INT_MIN) && (divisor_i == '1)) begin
                        result_d = w_is_rem ? '0 : C_INT_MIN;
                        state_d  = DONE;
                    end else begin
                        cnt_d    = CNT_W'(DIV_ITER - 1);
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = {quo_q[XLEN-2:0], ~w_diff[XLEN]};
                rem_d = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                result_d = is_rem_q ? w_rem_fix : w_quo_fix;
                state_d  = DONE;
            end
            DONE: begin
                if (ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_core_div_iter.sv
// ============================================================================
// Module      : tb_core_div_iter
// Description : Directed self-checking bench for core_div_iter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_div_iter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        ack_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int tests_run = 0;
    int tests_failed = 0;

    core_div_iter #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .funct3_i    (funct3_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .ack_i       (ack_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .result_o    (result_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance into the next cycle; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for cycle 0; returns in cycle 1 with the request dropped.
    task automatic start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        req_valid_i = 1'b1;
        funct3_i    = f3;
        dividend_i  = a;
        divisor_i   = b;
        step();
        req_valid_i = 1'b0;
    endtask

    // Called in cycle 1; lat is the cycle index at which valid_o is seen, -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_o && lat < 200) begin
            step();
            lat++;
        end
        if (!valid_o) lat = -1;
    endtask

    task automatic do_ack();
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        tests_run++;
        if (valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b expected 0", valid_o);
        end
        tests_run++;
        if (result_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h expected 00000000", result_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    // Table-driven ops: 10 vectors covering signed, unsigned and special cases.
    task automatic test_ops();
        logic [2:0]  f3  [10];
        logic [31:0] a   [10];
        logic [31:0] b   [10];
        logic [31:0] exp [10];
        int          lt  [10];
        int          lat;
        f3[0] = 3'b100; a[0] = 32'd100;        b[0] = 32'd7;          exp[0] = 32'd14;         lt[0] = 34;
        f3[1] = 3'b110; a[1] = 32'd100;        b[1] = 32'd7;          exp[1] = 32'd2;          lt[1] = 34;
        f3[2] = 3'b100; a[2] = 32'hFFFF_FFF9;  b[2] = 32'd2;          exp[2] = 32'hFFFF_FFFD;  lt[2] = 34;
        f3[3] = 3'b110; a[3] = 32'hFFFF_FFF9;  b[3] = 32'd2;          exp[3] = 32'hFFFF_FFFF;  lt[3] = 34;
        f3[4] = 3'b101; a[4] = 32'hFFFF_FFFF;  b[4] = 32'd2;          exp[4] = 32'h7FFF_FFFF;  lt[4] = 34;
        f3[5] = 3'b111; a[5] = 32'hFFFF_FFFF;  b[5] = 32'd2;          exp[5] = 32'd1;          lt[5] = 34;
        f3[6] = 3'b101; a[6] = 32'd5;          b[6] = 32'd0;          exp[6] = 32'hFFFF_FFFF;  lt[6] = 1;
        f3[7] = 3'b110; a[7] = 32'd5;          b[7] = 32'd0;          exp[7] = 32'd5;          lt[7] = 1;
        f3[8] = 3'b100; a[8] = 32'h8000_0000;  b[8] = 32'hFFFF_FFFF;  exp[8] = 32'h8000_0000;  lt[8] = 1;
        f3[9] = 3'b110; a[9] = 32'h8000_0000;  b[9] = 32'hFFFF_FFFF;  exp[9] = 32'd0;          lt[9] = 1;
        for (int i = 0; i < 10; i++) begin
            start(f3[i], a[i], b[i]);
            wait_valid(lat);
            tests_run++;
            if (lat !== lt[i]) begin
                tests_failed++;
                $display("FAIL op%0d_latency: got %0d expected %0d", i, lat, lt[i]);
            end
            tests_run++;
            if (result_o !== exp[i]) begin
                tests_failed++;
                $display("FAIL op%0d_result: got %h expected %h", i, result_o, exp[i]);
            end
            do_ack();
            tests_run++;
            if (busy_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL op%0d_busy_after_ack: got %b expected 0", i, busy_o);
            end
            step();
        end
    endtask

    task automatic test_hold_ack();
        int lat;
        int bad;
        start(3'b101, 32'd100, 32'd10);
        wait_valid(lat);
        tests_run++;
        if (lat !== 34) begin
            tests_failed++;
            $display("FAIL hold_latency: got %0d expected 34", lat);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (valid_o !== 1'b1 || result_o !== 32'd10) bad++;
            step();
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
        end
        // Cycle 39: ack with the next divide already held on the request.
        ack_i       = 1'b1;
        req_valid_i = 1'b1;
        funct3_i    = 3'b100;
        dividend_i  = 32'd9;
        divisor_i   = 32'd3;
        step();
        ack_i = 1'b0;
        tests_run++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_bubble_c40: got busy=%b valid=%b expected 0 0", busy_o, valid_o);
        end
        step();
        req_valid_i = 1'b0;
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_next_accept_c41: got %b expected 1", busy_o);
        end
        wait_valid(lat);
        tests_run++;
        if (lat !== 34 || result_o !== 32'd3) begin
            tests_failed++;
            $display("FAIL hold_next_result: got lat=%0d res=%h expected 34 00000003", lat, result_o);
        end
        do_ack();
        step();
    endtask

    task automatic test_flush();
        int seen_valid;
        int lat;
        seen_valid = 0;
        start(3'b100, 32'd1000, 32'd3);
        for (int c = 1; c < 10; c++) begin
            if (valid_o) seen_valid++;
            step();
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        if (valid_o) seen_valid++;
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle_c11: got busy=%b expected 0", busy_o);
        end
        tests_run++;
        if (seen_valid !== 0) begin
            tests_failed++;
            $display("FAIL flush_no_valid: got %0d valid cycles expected 0", seen_valid);
        end
        start(3'b100, 32'd9, 32'd3);
        wait_valid(lat);
        tests_run++;
        if (lat + 11 !== 45 || result_o !== 32'd3) begin
            tests_failed++;
            $display("FAIL flush_new_div: got cycle=%0d res=%h expected 45 00000003", lat + 11, result_o);
        end
        do_ack();
        step();
    endtask

    task automatic test_reset_mid();
        int lat;
        start(3'b100, 32'd1000, 32'd7);
        for (int c = 1; c < 20; c++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        tests_run++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: got busy=%b valid=%b res=%h expected 0 0 00000000",
                     busy_o, valid_o, result_o);
        end
        start(3'b111, 32'd17, 32'd5);
        wait_valid(lat);
        tests_run++;
        if (lat !== 34 || result_o !== 32'd2) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got lat=%0d res=%h expected 34 00000002", lat, result_o);
        end
        do_ack();
        step();
    endtask

    initial begin
        test_reset();
        test_ops();
        test_hold_ack();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/core_div_iter.md
# core_div_iter

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the responder side of the execute stage's multi-cycle handshake: the EX stage presents forwarded operands and holds the request while it stalls. This block computes the quotient or remainder over a fixed number of cycles, raises `valid_o`, and holds the result until the pipeline advances. It sits beside the ALU and multiplier inside the EX stage, and its `valid_o` feeds the stage's `ex_valid` stall term.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `req_valid_i` in 1: a divide instruction is in EX; held high until acked or flushed.
- `funct3_i` in 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; requests with funct3[2]=0 are ignored.
- `dividend_i` in XLEN: forwarded rs1.
- `divisor_i` in XLEN: forwarded rs2.
- `ack_i` in 1: pipeline advance; consumes a result held in DONE.
- `flush_i` in 1: kill any in-flight operation (branch/trap).
- `busy_o` out 1: state ≠ IDLE.
- `valid_o` out 1: result_o is valid (state DONE).
- `result_o` out XLEN: quotient or remainder; stable while valid_o=1.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Accept:** in IDLE with req_valid_i=1 and funct3_i[2]=1. On accept, latch op, |dividend|, |divisor|, the quotient sign (signed op and signs differ) and the remainder sign (signed op and dividend negative). For unsigned ops, magnitudes equal the raw operands.
- **Special cases (decided at accept, go IDLE→DONE directly):**
  - divisor=0: DIV/DIVU → 0xFFFF_FFFF; REM/REMU → dividend.
  - signed overflow (DIV/REM, dividend=0x8000_0000, divisor=0xFFFF_FFFF): DIV → 0x8000_0000; REM → 0.
- **CALC:** restoring division, one quotient bit per cycle, 5-bit counter from 31 down to 0. The partial remainder is 33 bits: shift in the next dividend MSB, trial-subtract the divisor, keep the result if it is non-negative, and shift the quotient bit in. At counter 0, go to FIX.
- **FIX:** negate the quotient and/or remainder per the latched signs, select by op, register into result_o, then go to DONE.
- **DONE:** valid_o=1 and result_o is held. On ack_i=1, go to IDLE.
  - A request is not accepted in the same cycle as ack; the next divide is accepted the following cycle, giving one bubble.
- **Flush:** flush_i=1 in any state → IDLE next cycle, valid_o=0, and no result is produced. Flush has priority over ack and accept.
- **Reset:** rst_i=1 → IDLE, busy_o=0, valid_o=0, result_o=0, counter=0. Reset has priority over flush.
- A request arriving while busy is never double-accepted; inputs are sampled only at accept.

## Timing
- Cycle 0 = the cycle in which the request is seen in IDLE.
- **Normal operation:**
  - CALC occupies cycles 1–32.
  - FIX occupies cycle 33.
  - DONE starts at cycle 34, with valid_o=1; the latency is 34 cycles.
- **Special cases:** DONE and valid_o=1 at cycle 1.
- **Hold:** valid_o and result_o hold for as long as ack_i=0, with no timeout.
- **busy_o:** high from cycle 1 until the cycle after ack or flush.
- **Outputs:** all outputs come from registers; no combinational path from inputs to valid_o or result_o.

## Structure
- **Shared package `core_div_pkg`:**
  - state enum `div_state_e` {IDLE, CALC, FIX, DONE};
  - funct3 localparams `F3_DIV`, `F3_DIVU`, `F3_REM`, `F3_REMU`;
  - `DIV_ITER = 32`.
- **Sub-modules:** none required. The single-bit step (shift/subtract/select) is local combinational logic inside core_div_iter.
- **EX stage integration:** `ex_valid = is_div ? valid_o : 1`.

## Test plan
- **Signed basics:** DIV 100/7 → 14 at cycle 34; REM 100/7 → 2. DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF.
- **Unsigned:** DIVU 0xFFFF_FFFF/2 → 0x7FFF_FFFF; REMU 0xFFFF_FFFF/2 → 1, both at cycle 34.
- **Divide by zero:** DIVU 5/0 → 0xFFFF_FFFF at cycle 1; REM 5/0 → 5 at cycle 1. Overflow: DIV 0x8000_0000/−1 → 0x8000_0000; REM → 0, both at cycle 1.
- **Hold then advance:** ack_i held low for 5 cycles after valid_o rises → result_o stable throughout. Ack at cycle 39 → busy_o=0 at 40. A held request for the next divide is accepted at 40.
- **Flush mid-CALC:** flush_i at cycle 10 → IDLE at 11, with valid_o never asserted. A new DIV 9/3 accepted at 11 → 3 at cycle 45.
- **Reset mid-operation:** rst_i at cycle 20 → next cycle busy_o=0, valid_o=0, result_o=0. The following request completes with the correct result.
